// File: rtl/controle_busca.sv
// Instruction-fetch controller: owns the PC, latches fetched words and hands them to decode over valid/ready.
// Optional STEP_EN macro adds the 'passo' single-step input; without it only the WAIT opcode halts fetch.
module controle_busca #(
  parameter int              ADDR_W   = 9,
  parameter int              DATA_W   = 32,
  parameter logic [5:0]      OP_WAIT  = 6'b101100,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              ck,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] endereco,
  input  logic [DATA_W-1:0] saida_mem,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [ADDR_W-1:0] pc_inst,
  input  logic              desvio,
  input  logic [ADDR_W-1:0] desvio_alvo,
  input  logic              continuar,
`ifdef STEP_EN
  input  logic              passo,
`endif
  output logic              parado
);

  typedef enum logic [1:0] {
    BUSCA,
    ENTREGA,
    PARADO
  } estado_t;

  estado_t           estado_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] inst_q;
  logic [ADDR_W-1:0] pc_inst_q;
  logic              valid_q;
  logic              parado_q;

  logic handshake;
  logic para_agora;

  assign handshake = valid_q & inst_ready;

  // The opcode is taken from the word being accepted, not from the one being read from memory.
`ifdef STEP_EN
  assign para_agora = (inst_q[DATA_W-1 -: 6] == OP_WAIT) | passo;
`else
  assign para_agora = (inst_q[DATA_W-1 -: 6] == OP_WAIT);
`endif

  // NOTE: all state here updates with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= BUSCA;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      pc_inst_q <= '0;
      valid_q   <= 1'b0;
      parado_q  <= 1'b0;
    end else if (desvio) begin
      // Redirect beats everything, including a concurrent WAIT or continuar.
      pc_q     <= desvio_alvo;
      valid_q  <= 1'b0;
      parado_q <= 1'b0;
      estado_q <= BUSCA;
    end else begin
      case (estado_q)
        BUSCA: begin
          inst_q    <= saida_mem;
          pc_inst_q <= pc_q;
          pc_q      <= pc_q + 1'b1;
          valid_q   <= 1'b1;
          estado_q  <= ENTREGA;
        end
        ENTREGA: begin
          if (handshake) begin
            if (para_agora) begin
              valid_q  <= 1'b0;
              parado_q <= 1'b1;
              estado_q <= PARADO;
            end else begin
              inst_q    <= saida_mem;
              pc_inst_q <= pc_q;
              pc_q      <= pc_q + 1'b1;
            end
          end
        end
        PARADO: begin
          if (continuar) begin
            parado_q <= 1'b0;
            estado_q <= BUSCA;
          end
        end
        default: begin
          estado_q <= BUSCA;
          valid_q  <= 1'b0;
          parado_q <= 1'b0;
        end
      endcase
    end
  end

  assign endereco   = pc_q;
  assign inst       = inst_q;
  assign inst_valid = valid_q;
  assign pc_inst    = pc_inst_q;
  assign parado     = parado_q;

endmodule

// File: tb/tb_controle_busca.sv
// Self-checking bench for controle_busca: memory model plus a scoreboard of expected fetch addresses.
module tb_controle_busca;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  logic              ck;
  logic              rst_n;
  logic [ADDR_W-1:0] endereco;
  logic [DATA_W-1:0] saida_mem;
  logic [DATA_W-1:0] inst;
  logic              inst_valid;
  logic              inst_ready;
  logic [ADDR_W-1:0] pc_inst;
  logic              desvio;
  logic [ADDR_W-1:0] desvio_alvo;
  logic              continuar;
  logic              parado;
`ifdef STEP_EN
  logic              passo;
`endif

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] sb_q [$];
  int checks;
  int failures;
  int entregues;

  assign saida_mem = mem[endereco];

  controle_busca dut (
    .ck          (ck),
    .rst_n       (rst_n),
    .endereco    (endereco),
    .saida_mem   (saida_mem),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .pc_inst     (pc_inst),
    .desvio      (desvio),
    .desvio_alvo (desvio_alvo),
    .continuar   (continuar),
`ifdef STEP_EN
    .passo       (passo),
`endif
    .parado      (parado)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor at the negedge (inputs stable), then advance past the next rising edge.
  task automatic tick();
    logic [ADDR_W-1:0] e;
    @(negedge ck);
    if (inst_valid && inst_ready) begin
      entregues++;
      if (sb_q.size() == 0) begin
        check("sb_unexpected", {23'd0, pc_inst}, 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        check("sb_pc", {23'd0, pc_inst}, {23'd0, e});
        check("sb_inst", inst, mem[e]);
      end
    end
    @(posedge ck);
    #1;
  endtask

  task automatic push_range(input int a, input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(ADDR_W'(a + i));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    entregues = 0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'(i);
    rst_n = 1'b0;
    inst_ready = 1'b1;
    desvio = 1'b0;
    desvio_alvo = '0;
    continuar = 1'b0;
`ifdef STEP_EN
    passo = 1'b0;
`endif
    tick();
    tick();
    check("rst_valid", inst_valid, 0);
    check("rst_pc_inst", pc_inst, 0);
    check("rst_inst", inst, 0);
    check("rst_parado", parado, 0);
    check("rst_endereco", endereco, 0);

    // Streaming, then a 3-cycle stall at pc_inst=2.
    push_range(0, 5);
    rst_n = 1'b1;
    check("rel_valid_low", inst_valid, 0);
    tick();
    check("first_valid", inst_valid, 1);
    check("first_pc", pc_inst, 0);
    tick();
    tick();
    inst_ready = 1'b0;
    check("stall_pc0", pc_inst, 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", pc_inst, 2);
      check("stall_inst", inst, 2);
      check("stall_end", endereco, 3);
      check("stall_valid", inst_valid, 1);
    end
    inst_ready = 1'b1;
    tick();
    check("after_stall_pc", pc_inst, 3);
    tick();
    check("pre_desvio_pc", pc_inst, 4);

    // Redirect with a concurrent handshake: 4 consumed, 5 and 6 skipped.
    desvio = 1'b1;
    desvio_alvo = 9'd7;
    tick();
    desvio = 1'b0;
    check("flush_valid", inst_valid, 0);
    check("flush_end", endereco, 7);
    push_range(7, 2);
    tick();
    check("tgt_pc", pc_inst, 7);
    tick();
    tick();
    inst_ready = 1'b0;
    check("sb_empty_a", sb_q.size(), 0);

    // Redirect to the top of the address space: PC wraps.
    desvio = 1'b1;
    desvio_alvo = 9'd511;
    tick();
    desvio = 1'b0;
    sb_q.push_back(9'd511);
    push_range(0, 2);
    inst_ready = 1'b1;
    tick();
    check("wrap_pc511", pc_inst, 511);
    check("wrap_end", endereco, 0);
    tick();
    check("wrap_pc0", pc_inst, 0);
    tick();
    tick();
    inst_ready = 1'b0;
    check("sb_empty_b", sb_q.size(), 0);

    // Asynchronous reset in the middle of a cycle while delivering.
    check("pre_rst_valid", inst_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", inst_valid, 0);
    check("async_pc_inst", pc_inst, 0);
    check("async_end", endereco, 0);
    tick();

    // WAIT at address 0: delivered, then halt until continuar.
    mem[0] = 32'hB000_0000;
    inst_ready = 1'b1;
    push_range(0, 2);
    rst_n = 1'b1;
    tick();
    check("wait_inst", inst, 32'hB000_0000);
    tick();
    check("wait_parado", parado, 1);
    check("wait_valid", inst_valid, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_parado", parado, 1);
      check("hold_valid", inst_valid, 0);
      check("hold_end", endereco, 1);
    end
    continuar = 1'b1;
    tick();
    continuar = 1'b0;
    check("resume_parado", parado, 0);
    tick();
    check("resume_pc", pc_inst, 1);
    tick();
    inst_ready = 1'b0;
    mem[0] = 32'd0;
    check("sb_empty_c", sb_q.size(), 0);

    // Redirect while halted, together with continuar: target wins.
    mem[3] = 32'hB000_0003;
    push_range(2, 2);
    sb_q.push_back(9'd20);
    inst_ready = 1'b1;
    tick();
    tick();
    check("wait2_parado", parado, 1);
    desvio = 1'b1;
    desvio_alvo = 9'd20;
    continuar = 1'b1;
    tick();
    desvio = 1'b0;
    continuar = 1'b0;
    check("park_desvio_parado", parado, 0);
    check("park_desvio_end", endereco, 20);
    tick();
    check("park_tgt_pc", pc_inst, 20);
    tick();
    inst_ready = 1'b0;
    check("sb_empty_d", sb_q.size(), 0);

`ifdef STEP_EN
    // Single step: one instruction per continuar pulse.
    passo = 1'b1;
    inst_ready = 1'b1;
    push_range(21, 3);
    tick();
    check("step_parado", parado, 1);
    for (int k = 0; k < 2; k++) begin
      entregues = 0;
      tick();
      tick();
      check("step_idle_valid", inst_valid, 0);
      continuar = 1'b1;
      tick();
      continuar = 1'b0;
      tick();
      check("step_pc", pc_inst, 22 + k);
      tick();
      tick();
      check("step_count", entregues, 1);
      check("step_parado_k", parado, 1);
    end
    passo = 1'b0;
    check("sb_empty_e", sb_q.size(), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
